// File: rtl/pipe_rdr_pkg.sv
// Shared definitions for the pipeline result reader: reader FSM state encoding and word/byte widths.
package pipe_rdr_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HI   = 2'd1,
      S_LO   = 2'd2
   } rdr_state_t;

endpackage

// File: rtl/rdr_fifo.sv
// Synchronous word FIFO with push/pop/full/empty and a registered occupancy count.
module rdr_fifo
   import pipe_rdr_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_level
);

   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
   assign w_do_push = i_push && (r_count != FULL_LVL);
   assign w_do_pop  = i_pop && (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr];
   assign o_full    = (r_count == FULL_LVL);
   assign o_empty   = (r_count == '0);
   assign o_level   = r_count;

endmodule

// File: rtl/pipe_result_reader.sv
// Buffers 16-bit pipeline results and serializes them high byte first over a valid/ready byte port.
// Optional out_parity port is enabled by defining RDR_PARITY_EN.
module pipe_result_reader
   import pipe_rdr_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [BYTE_W-1:0] out_byte,
   output logic              out_last,
   input  logic              out_ready,
   output logic [AW:0]       level,
   output logic              overflow
`ifdef RDR_PARITY_EN
   ,
   output logic              out_parity
`endif
);

   rdr_state_t        r_state;
   logic [WORD_W-1:0] r_hold;
   logic              r_out_valid;
   logic [BYTE_W-1:0] r_out_byte;
   logic              r_out_last;
   logic              r_overflow;
   logic [WORD_W-1:0] w_rd_data;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   assign w_push = in_valid && !w_full;
   // Pop from idle, or back-to-back as the low byte is accepted so words stream without a bubble.
   assign w_pop  = !w_empty && ((r_state == S_IDLE) || ((r_state == S_LO) && out_ready));

   rdr_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (w_push),
      .i_wr_data (in_data),
      .i_pop     (w_pop),
      .o_rd_data (w_rd_data),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (level)
   );

   always_ff @(posedge clk) begin
      if (w_pop)
         r_hold <= w_rd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
         r_out_byte  <= '0;
         r_out_last  <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         if (in_valid && w_full)
            r_overflow <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_out_valid <= 1'b1;
                  r_out_byte  <= w_rd_data[WORD_W-1:BYTE_W];
                  r_out_last  <= 1'b0;
                  r_state     <= S_HI;
               end
            end
            S_HI: begin
               if (out_ready) begin
                  r_out_byte <= r_hold[BYTE_W-1:0];
                  r_out_last <= 1'b1;
                  r_state    <= S_LO;
               end
            end
            S_LO: begin
               if (out_ready) begin
                  if (w_pop) begin
                     r_out_byte <= w_rd_data[WORD_W-1:BYTE_W];
                     r_out_last <= 1'b0;
                     r_state    <= S_HI;
                  end else begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_state     <= S_IDLE;
                  end
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = !w_full;
   assign out_valid = r_out_valid;
   assign out_byte  = r_out_byte;
   assign out_last  = r_out_last;
   assign overflow  = r_overflow;

`ifdef RDR_PARITY_EN
   assign out_parity = r_out_valid & (^r_out_byte);
`endif

endmodule
